alu_result_reg: RTL and testbench

- Registered output stage that sits directly downstream of the 64-bit ALU datapath (bitwise AND/OR/XOR, adder).
- Captures each ALU result through a 2-entry valid/ready skid buffer and hands it to the writeback stage.
- Maintains the architectural NZCV flag register, updated only when a flag-setting result is committed (popped).

---
 rtl/alu_result_reg.sv | 93 +++++++++
 tb/tb_alu_result_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_reg.sv
// alu_result_reg: two-entry skid buffer after the ALU that holds the committed NZCV flags.
// Defining ALU_RESULT_STALL_COUNT_EN adds a saturating stall_count output.
module alu_result_reg #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carry,
   input  logic             in_overflow,
   input  logic             in_set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       flags
`ifdef ALU_RESULT_STALL_COUNT_EN
   ,
   output logic [15:0]      stall_count
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_q [2];
   logic [1:0]       carry_q;
   logic [1:0]       ovf_q;
   logic [1:0]       sf_q;
   logic [CW-1:0]    count;
   logic             head;
   logic             tail;
   logic             push;
   logic             pop;

   assign in_ready   = (count != DEPTH[CW-1:0]);
   assign out_valid  = (count != '0);
   assign out_result = data_q[head];
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   // with one entry held, the free slot is always the one opposite the head
   assign tail       = head ^ count[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         carry_q   <= '0;
         ovf_q     <= '0;
         sf_q      <= '0;
         count     <= '0;
         head      <= 1'b0;
         flags     <= 4'b0000;
      end else begin
         if (pop) begin
            data_q[head]  <= '0;
            carry_q[head] <= 1'b0;
            ovf_q[head]   <= 1'b0;
            sf_q[head]    <= 1'b0;
            head          <= ~head;
            if (sf_q[head]) begin
               flags <= {data_q[head][WIDTH-1],
                         (data_q[head] == '0),
                         carry_q[head],
                         ovf_q[head]};
            end
         end
         if (push) begin
            data_q[tail]  <= in_result;
            carry_q[tail] <= in_carry;
            ovf_q[tail]   <= in_overflow;
            sf_q[tail]    <= in_set_flags;
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

`ifdef ALU_RESULT_STALL_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
         stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_reg.sv
// tb_alu_result_reg: table vectors plus hand sequences, scoreboard queue
// holding expected entries in FIFO order.
module tb_alu_result_reg;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_result;
   logic        in_carry;
   logic        in_overflow;
   logic        in_set_flags;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [3:0]  flags;
`ifdef ALU_RESULT_STALL_COUNT_EN
   logic [15:0] stall_count;
`endif

   alu_result_reg #(.WIDTH(64), .DEPTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_carry     (in_carry),
      .in_overflow  (in_overflow),
      .in_set_flags (in_set_flags),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .flags        (flags)
`ifdef ALU_RESULT_STALL_COUNT_EN
      ,
      .stall_count  (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] r;
      logic        c;
      logic        o;
      logic        sf;
   } entry_t;

   typedef struct {
      logic [63:0] r;
      logic        c;
      logic        o;
      logic        sf;
      logic [3:0]  exp_flags;
   } vec_t;

   entry_t q[$];
   logic [3:0] mflags;
   int n_cmp;
   int n_bad;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one cycle: drive at negedge, check, update model, advance to next negedge
   task automatic step(input logic v, input logic [63:0] r, input logic c,
                       input logic o, input logic sf, input logic ordy,
                       output logic pushed);
      entry_t e;
      logic popped;
      in_valid = v;
      in_result = r;
      in_carry = c;
      in_overflow = o;
      in_set_flags = sf;
      out_ready = ordy;
      #1;
      check("in_ready", {63'd0, in_ready}, {63'd0, q.size() != 2});
      check("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      check("flags", {60'd0, flags}, {60'd0, mflags});
      if (q.size() == 0) check("empty_result", out_result, 64'd0);
      pushed = v && (q.size() != 2);
      popped = ordy && (q.size() != 0);
      if (popped) begin
         e = q.pop_front();
         check("out_result", out_result, e.r);
         if (e.sf) mflags = {e.r[63], e.r == 64'd0, e.c, e.o};
      end
      if (pushed) begin
         e.r = r;
         e.c = c;
         e.o = o;
         e.sf = sf;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      logic p;
      step(1'b0, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, ordy, p);
   endtask

   vec_t vecs[7];
   logic pushed;
   int guard;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      mflags = 4'b0000;
      vecs[0] = '{64'd8320, 1'b0, 1'b0, 1'b1, 4'b0000};
      vecs[1] = '{64'd0, 1'b0, 1'b0, 1'b1, 4'b0100};
      vecs[2] = '{64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 4'b1011};
      vecs[3] = '{64'd0, 1'b0, 1'b0, 1'b1, 4'b0100};
      vecs[4] = '{64'd5, 1'b0, 1'b0, 1'b0, 4'b0100};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 4'b1010};
      vecs[6] = '{64'd1, 1'b0, 1'b1, 1'b1, 4'b0001};

      reset = 1'b0;
      in_valid = 1'b0;
      in_result = '0;
      in_carry = 1'b0;
      in_overflow = 1'b0;
      in_set_flags = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_flags", {60'd0, flags}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // table: push, pop next cycle, then flags visible the cycle after
      for (int i = 0; i < 7; i++) begin
         step(1'b1, vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].sf, 1'b1, pushed);
         check("vec_push", {63'd0, pushed}, 64'd1);
         check("vec_latency", {63'd0, out_valid}, 64'd1);
         check("vec_head", out_result, vecs[i].r);
         idle(1'b1);
         check("vec_flags", {60'd0, flags}, {60'd0, vecs[i].exp_flags});
      end

      // backpressure: third push refused until a pop frees a slot
      step(1'b1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, pushed);
      step(1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0, pushed);
      check("bp_full", {63'd0, in_ready}, 64'd0);
      step(1'b1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, pushed);
      check("bp_refused", {63'd0, pushed}, 64'd0);
      check("bp_head", out_result, 64'd1);
      guard = 0;
      pushed = 1'b0;
      while (!pushed && guard < 10) begin
         step(1'b1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1, pushed);
         guard++;
      end
      check("bp_accept_bound", {63'd0, pushed}, 64'd1);
      repeat (3) idle(1'b1);
      check("bp_drained", {63'd0, out_valid}, 64'd0);

      // streaming: push and pop together at count=1
      step(1'b1, 64'd10, 1'b0, 1'b0, 1'b0, 1'b1, pushed);
      for (int i = 11; i <= 19; i++) begin
         check("stream_head", out_result, 64'(i - 1));
         step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0, 1'b1, pushed);
         check("stream_count1", {62'd0, out_valid, in_ready}, 64'd3);
      end
      check("stream_last", out_result, 64'd19);
      idle(1'b1);
      idle(1'b1);

      // mid-operation reset with flags=1000 and two entries buffered
      step(1'b1, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b1, 1'b1, pushed);
      idle(1'b1);
      idle(1'b0);
      check("pre_rst_flags", {60'd0, flags}, 64'h8);
      step(1'b1, 64'd7, 1'b1, 1'b0, 1'b1, 1'b0, pushed);
      step(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, pushed);
      in_valid = 1'b0;
      check("pre_rst_full", {63'd0, in_ready}, 64'd0);
`ifdef ALU_RESULT_STALL_COUNT_EN
      check("pre_rst_stall", 64'(stall_count != 16'd0), 64'd1);
`endif
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_flags", {60'd0, flags}, 64'd0);
      check("mid_rst_result", out_result, 64'd0);
`ifdef ALU_RESULT_STALL_COUNT_EN
      check("mid_rst_stall", {48'd0, stall_count}, 64'd0);
`endif
      #3;
      reset = 1'b1;
      q.delete();
      mflags = 4'b0000;
      @(negedge clk);
      idle(1'b1);
      idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
